// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the iterative RV32M
// multiply/divide sequencer.
//   XLEN / CNT_W    : datapath width and iteration counter width
//   state_e         : sequencer states IDLE -> CALC -> FIX -> DONE
//   OP_*            : funct3 encodings of the M-extension operations
//   FUNCT7_MULDIV   : funct7 that identifies an M-extension instruction
package muldiv_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and the
// multiply/divide sequencer.
//   start_i, funct3_i, rs1_data_i, rs2_data_i : request (CPU -> sequencer)
//   busy_o, done_o, result_o                  : status/result (sequencer -> CPU)
// master = CPU side, slave = sequencer side.
interface muldiv_if;
   import muldiv_pkg::*;

   logic            start_i;
   logic [2:0]      funct3_i;
   logic [XLEN-1:0] rs1_data_i;
   logic [XLEN-1:0] rs2_data_i;
   logic            busy_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output start_i, funct3_i, rs1_data_i, rs2_data_i,
      input  busy_o, done_o, result_o
   );

   modport slave (
      input  start_i, funct3_i, rs1_data_i, rs2_data_i,
      output busy_o, done_o, result_o
   );

endinterface

// File: rtl/muldiv_iter_step.sv
// muldiv_iter_step: one combinational iteration of the multiply/divide loop.
//   div_mode_i : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i      : 64-bit accumulator
//                  multiply: {partial product high, multiplier / product low}
//                  divide  : {partial remainder, dividend / quotient}
//   opd_i      : multiplicand (multiply) or divisor (divide)
//   acc_o      : accumulator after this iteration
module muldiv_iter_step
   import muldiv_pkg::*;
(
   input  logic              div_mode_i,
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   opd_i,
   output logic [2*XLEN-1:0] acc_o
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   rem_sh;
   logic [XLEN-1:0] diff;

   always_comb begin
      // Multiply: add multiplicand when the current multiplier LSB is set,
      // keep the carry as bit 32 and shift the whole register right.
      sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opd_i} : '0);
      // Divide: shift the next dividend bit into the remainder. The shifted
      // remainder needs 33 bits; once the divisor fits, the difference
      // always fits back into 32.
      rem_sh = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
      diff   = rem_sh[XLEN-1:0] - opd_i;
      if (div_mode_i) begin
         if (rem_sh >= {1'b0, opd_i})
            acc_o = {diff, acc_i[XLEN-2:0], 1'b1};
         else
            acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end else begin
         acc_o = {sum, acc_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide controller.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : start_i/funct3_i/rs1_data_i/rs2_data_i request,
//                  busy_o (CALC/FIX), done_o (1-cycle pulse), result_o
// Operands are converted to magnitudes on start; the unsigned 32-step loop
// runs in CALC and the sign is restored in FIX.
// Build option MULDIV_EARLY_OUT_EN: zero operands (including divide by
// zero) finish straight from IDLE to DONE with an identical result.
module muldiv_sequencer
   import muldiv_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   muldiv_if.slave bus
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opd_q, opd_d;
   logic [2:0]        f3_q, f3_d;
   logic              neg_q, neg_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic [2*XLEN-1:0] acc_step;
   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_abs, b_abs;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem;

   muldiv_iter_step u_step (
      .div_mode_i (f3_q[2]),
      .acc_i      (acc_q),
      .opd_i      (opd_q),
      .acc_o      (acc_step)
   );

`ifdef MULDIV_EARLY_OUT_EN
   function automatic logic [XLEN-1:0] early_result(
      input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      if (!f3[2])       return '0;                      // any product with a 0
      else if (b == '0) return f3[1] ? a : '1;          // REM* = a, DIV* = all ones
      else              return '0;                      // 0 / b, 0 % b
   endfunction
`endif

   always_comb begin
      // Operand sign handling: A signed for MULH/MULHSU/DIV/REM,
      // B signed for MULH/DIV/REM.
      a_neg = bus.rs1_data_i[XLEN-1] &&
              (bus.funct3_i == OP_MULH || bus.funct3_i == OP_MULHSU ||
               bus.funct3_i == OP_DIV  || bus.funct3_i == OP_REM);
      b_neg = bus.rs2_data_i[XLEN-1] &&
              (bus.funct3_i == OP_MULH || bus.funct3_i == OP_DIV ||
               bus.funct3_i == OP_REM);
      a_abs = a_neg ? -bus.rs1_data_i : bus.rs1_data_i;
      b_abs = b_neg ? -bus.rs2_data_i : bus.rs2_data_i;

      prod  = neg_q ? -acc_q : acc_q;
      quo   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem   = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opd_d    = opd_q;
      f3_d     = f3_q;
      neg_d    = neg_q;
      result_d = result_q;

      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               f3_d  = bus.funct3_i;
               cnt_d = '0;
               // Divide by zero keeps a positive quotient (all ones);
               // remainder always follows the dividend.
               case (bus.funct3_i)
                  OP_DIV:          neg_d = (a_neg ^ b_neg) && (bus.rs2_data_i != '0);
                  OP_REM, OP_REMU: neg_d = a_neg;
                  default:         neg_d = a_neg ^ b_neg;
               endcase
               if (bus.funct3_i[2]) begin
                  acc_d = {{XLEN{1'b0}}, a_abs};
                  opd_d = b_abs;
               end else begin
                  acc_d = {{XLEN{1'b0}}, b_abs};
                  opd_d = a_abs;
               end
`ifdef MULDIV_EARLY_OUT_EN
               if (bus.rs1_data_i == '0 || bus.rs2_data_i == '0) begin
                  result_d = early_result(bus.funct3_i, bus.rs1_data_i, bus.rs2_data_i);
                  state_d  = DONE;
               end else begin
                  state_d = CALC;
               end
`else
               state_d = CALC;
`endif
            end
         end
         CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN-1))
               state_d = FIX;
         end
         FIX: begin
            case (f3_q)
               OP_MUL:                       result_d = prod[XLEN-1:0];
               OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod[2*XLEN-1:XLEN];
               OP_DIV, OP_DIVU:              result_d = quo;
               default:                      result_d = rem;
            endcase
            state_d = DONE;
         end
         default: state_d = IDLE;   // DONE: start_i is ignored here
      endcase

      busy_d = (state_d == CALC) || (state_d == FIX);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opd_q    <= '0;
         f3_q     <= '0;
         neg_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opd_q    <= opd_d;
         f3_q     <= f3_d;
         neg_q    <= neg_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign bus.busy_o   = busy_q;
   assign bus.done_o   = done_q;
   assign bus.result_o = result_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide controller attached to the CPU execute datapath beside the ALU.
- Accepts one M-extension operation (funct7 = 0000001, opcode 0110011) with both register operands.
- Sequences a 32-step shift-add or restoring-divide loop and raises busy_o so the CPU holds PC and pipeline state.
- Returns the 32-bit result for the register-file write port, with a one-cycle done_o pulse.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request; sampled only in IDLE.
- funct3_i  input  3  instruction[14:12]; selects the M operation.
- rs1_data_i  input  32  operand A (dividend / multiplicand).
- rs2_data_i  input  32  operand B (divisor / multiplier).
- busy_o  output  1  high in CALC and FIX; CPU stalls PC and register write.
- done_o  output  1  one-cycle pulse; result_o is valid.
- result_o  output  32  result; holds the last value until the next completion.

Behaviour:
- Reset: state = IDLE, busy_o = 0, done_o = 0, result_o = 0, counter = 0, internal accumulators = 0.
- rst_i overrides everything, including mid-CALC or FIX: the operation is aborted, no done_o pulse, IDLE next cycle.
- Encodings: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- IDLE: if start_i = 1, latch funct3 and operands, take absolute values where the op is signed, record result sign, counter = 0, go to CALC. Otherwise stay.
- CALC, 32 cycles:
  - Multiply: 64-bit product register; one shift-add per cycle, LSB first.
  - Divide: restoring, one quotient bit per cycle, MSB first.
  - Counter increments each cycle; at counter = 31 go to FIX.
- FIX, 1 cycle: apply sign correction (two's-complement negate) and select the result:
  - MUL: low word.
  - MULH, MULHSU, MULHU: high word.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder; remainder takes the sign of the dividend.
  - Write result_o; go to DONE.
- DONE, 1 cycle: done_o = 1, busy_o = 0; go to IDLE. A start_i in DONE is ignored.
- Latency: start_i accepted in cycle 0 → busy_o high in cycles 1–33 → done_o high in cycle 34. Throughput is one op per 35 cycles.
- start_i while busy or in DONE is ignored; no queueing.
- Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = dividend (REM and REMU); no exception.
- Signed overflow 0x80000000 / 0xFFFFFFFF: DIV = 0x80000000, REM = 0.
- Width rules:
  - Operand A is extended to 33 bits, signed for MULH/MULHSU, unsigned for MULHU.
  - Operand B is signed only for MULH.
  - Remainder arithmetic is 33-bit to hold the borrow.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: in IDLE, if rs2_data_i == 0 or rs1_data_i == 0 (any op), or a divide by zero occurs, compute the result directly and go IDLE → DONE. done_o is then in cycle 1 and busy_o never asserts.
- Undefined: every op takes the full 34-cycle path.
- Results are bit-identical in both builds.

Decomposition:
- Shared package muldiv_pkg holds:
  - XLEN and CNT_W constants.
  - State enum {IDLE, CALC, FIX, DONE}.
  - funct3 op constants (OP_MUL … OP_REMU).
  - M-extension funct7 constant 7'b0000001.
- One sub-module, muldiv_iter_step: purely combinational single iteration.
  - Inputs: mode, partial accumulator, operand.
  - Output: next accumulator.
  - Keeps the sequencer FSM separate from the arithmetic.

Test Plan:
- MUL rs1 = 7, rs2 = 0xFFFFFFFD (−3) → done_o in cycle 34 exactly, result 0xFFFFFFEB; busy_o high cycles 1–33 only.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- Corner cases:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5.
- Handshake and reset:
  - Second start_i in cycle 5 ignored; only one done_o pulse, at cycle 34.
  - rst_i in cycle 10: busy_o = 0 and result_o = 0 in cycle 11, no done_o.
  - A new MUL 3 × 4 then yields 12.
- With MULDIV_EARLY_OUT_EN: MUL 12345 × 0 → done_o cycle 1, result 0, busy_o never high. Without it: same result at cycle 34.
